// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Byte FIFO on the echo path from uart_rx into uart_tx.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int         DEPTH_LOG2 = 4,
    parameter int         LINE_MODE  = 0,
    parameter logic [7:0] EOL_CHAR   = 8'h0D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_rcv,
    input  logic [7:0]            rx_data,
    input  logic                  tx_ready,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  clr_ovf
);

    localparam logic [DEPTH_LOG2:0]   c_DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [7:0]            r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   r_eol_cnt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_ovf;
    state_t                r_state;
    logic [1:0]            r_tmo;
    logic                  r_tx_start;
    logic [7:0]            r_tx_data;

    logic                  w_wr_en;
    logic                  w_pop;
    logic                  w_wr_eol;
    logic                  w_pop_eol;
    logic                  w_line_ok;
    logic                  w_drain_ok;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    assign w_wr_en    = rx_rcv & ~r_full;
    // A full FIFO drains even without a terminator so line mode cannot deadlock.
    assign w_line_ok  = (r_eol_cnt != '0) | r_full;
    assign w_drain_ok = (LINE_MODE != 0) ? w_line_ok : 1'b1;
    assign w_pop      = (r_state == S_IDLE) & ~r_empty & w_drain_ok & tx_ready;
    assign w_wr_eol   = w_wr_en & (rx_data == EOL_CHAR);
    assign w_pop_eol  = w_pop & (r_mem[r_rd_ptr] == EOL_CHAR);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_en && !w_pop)
            w_count_nxt = r_count + c_CNT_ONE;
        else if (!w_wr_en && w_pop)
            w_count_nxt = r_count - c_CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_ovf     <= 1'b0;
            r_eol_cnt <= '0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            r_empty <= (w_count_nxt == '0);
            // Full is the pre-cycle flag, so a same-cycle pop does not rescue the byte.
            if (rx_rcv && r_full)
                r_ovf <= 1'b1;
            else if (clr_ovf)
                r_ovf <= 1'b0;
            if (w_wr_eol && !w_pop_eol)
                r_eol_cnt <= r_eol_cnt + c_CNT_ONE;
            else if (!w_wr_eol && w_pop_eol)
                r_eol_cnt <= r_eol_cnt - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_tmo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= r_mem[r_rd_ptr];
                        r_tx_start <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_tx_start <= 1'b0;
                    r_tmo      <= '0;
                    r_state    <= S_BUSY;
                end
                S_BUSY: begin
                    // Give up waiting for the ready drop after four cycles.
                    if (!tx_ready || r_tmo == 2'd3)
                        r_state <= S_DONE;
                    else
                        r_tmo <= r_tmo + 2'd1;
                end
                S_DONE: begin
                    if (tx_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign count    = r_count;
    assign full     = r_full;
    assign empty    = r_empty;
    assign overflow = r_ovf;

endmodule

`default_nettype wire
